// File: rtl/mips_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mips_alu : 32-bit EX-stage ALU, combinational result/equality flag plus |
// |            registered copies. Optional macro ALU_OVERFLOW_EN adds       |
// |            overflow / sticky overflow_q outputs.                        |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic             isEqual,
  output logic [WIDTH-1:0] C_q,
  output logic             isEqual_q
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow,
  output logic             overflow_q
`endif
);

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_OR   = 3'b010;
  localparam logic [2:0] c_OP_LUI  = 3'b011;
  localparam logic [2:0] c_OP_AND  = 3'b100;
  localparam logic [2:0] c_OP_XOR  = 3'b101;
  localparam logic [2:0] c_OP_SLT  = 3'b110;
  localparam logic [2:0] c_OP_SLTU = 3'b111;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic             w_sltu;

  assign w_sum   = A + B;
  assign w_diff  = A - B;
  assign w_slt   = ($signed(A) < $signed(B));
  assign w_sltu  = (A < B);
  assign isEqual = (A == B);

  always_comb begin
    C = '0;
    case (ALUOp)
      c_OP_ADD:  C = w_sum;
      c_OP_SUB:  C = w_diff;
      c_OP_OR:   C = A | B;
      c_OP_LUI:  C = {B[15:0], 16'h0000};
      c_OP_AND:  C = A & B;
      c_OP_XOR:  C = A ^ B;
      c_OP_SLT:  C = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_SLTU: C = {{(WIDTH-1){1'b0}}, w_sltu};
      default:   C = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      C_q       <= '0;
      isEqual_q <= 1'b0;
    end else begin
      C_q       <= C;
      isEqual_q <= isEqual;
    end
  end

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    overflow = 1'b0;
    case (ALUOp)
      c_OP_ADD: overflow = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1]);
      c_OP_SUB: overflow = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      default:  overflow = 1'b0;
    endcase
  end

  // Sticky: once set, only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (overflow) begin
      overflow_q <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mips_alu : self-checking scoreboard bench for mips_alu.             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_mips_alu;

  typedef struct packed {
    logic [31:0] c;
    logic        eq;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] C;
  logic        isEqual;
  logic [31:0] C_q;
  logic        isEqual_q;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
  logic        overflow_q;
`endif

  int   n_checks;
  int   n_errors;
  exp_t q_comb[$];
  exp_t q_reg[$];

  mips_alu #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .C         (C),
    .isEqual   (isEqual),
    .C_q       (C_q),
    .isEqual_q (isEqual_q)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow  (overflow),
    .overflow_q(overflow_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written from the opcode table, independent of the RTL structure.
  function automatic logic [31:0] model_c(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic lt_s;
    lt_s = (a[31] & ~b[31]) | (~(a[31] ^ b[31]) & (a < b));
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + ~b + 32'd1;
      3'd2:    return a | b;
      3'd3:    return b << 16;
      3'd4:    return a & b;
      3'd5:    return a ^ b;
      3'd6:    return lt_s ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

`ifdef ALU_OVERFLOW_EN
  function automatic logic model_ov(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd0) r = sa + sb;
    else if (op == 3'd1) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction
`endif

  task automatic pop_check(input string tag, inout exp_t q[$], input logic [31:0] obs_c, input logic obs_eq);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard empty observed=%h expected=entry", tag, obs_c);
    end else begin
      e = q.pop_front();
      check({tag, "_c"}, obs_c, e.c);
      check({tag, "_eq"}, {31'd0, obs_eq}, {31'd0, e.eq});
    end
  endtask

  // One vector per cycle: drive on negedge, check comb, check registered copy after posedge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    @(negedge clk);
    A = a; B = b; ALUOp = op;
    e.c  = model_c(a, b, op);
    e.eq = (a == b);
    q_comb.push_back(e);
    q_reg.push_back(e);
    #1;
    pop_check("comb", q_comb, C, isEqual);
`ifdef ALU_OVERFLOW_EN
    check("overflow", {31'd0, overflow}, {31'd0, model_ov(a, b, op)});
`endif
    @(posedge clk);
    #1;
    pop_check("reg", q_reg, C_q, isEqual_q);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] hold_c;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    A = '0; B = '0; ALUOp = 3'd0;
    #2;
    check("rst_cq", C_q, 32'd0);
    check("rst_eq", {31'd0, isEqual_q}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases and boundaries
    apply(32'h0000_0000, 32'h0000_FFFF, 3'b011);
    apply(32'h7FFF_FFFF, 32'h0000_0001, 3'b000);
`ifdef ALU_OVERFLOW_EN
    check("ovq_set", {31'd0, overflow_q}, 32'd1);
`endif
    apply(32'd5, 32'd5, 3'b001);
    apply(32'd0, 32'd1, 3'b001);
    apply(32'h8000_0000, 32'h0000_0001, 3'b110);
    apply(32'h8000_0000, 32'h0000_0001, 3'b111);
    apply(32'h8000_0000, 32'h0000_0001, 3'b010);
    apply(32'h8000_0000, 32'h0000_0001, 3'b100);
    apply(32'h8000_0000, 32'h0000_0001, 3'b101);
    apply(32'h8000_0000, 32'h0000_0000, 3'b110);
    apply(32'h8000_0000, 32'h0000_0000, 3'b111);
    apply(32'h8000_0000, 32'h0000_0001, 3'b001);

    // Async reset mid-cycle with no clock edge
    apply(32'h1234_5678, 32'h1234_5678, 3'b010);
    #2;
    reset = 1'b0;
    #1;
    check("async_cq", C_q, 32'd0);
    check("async_eq", {31'd0, isEqual_q}, 32'd0);
    check("async_c", C, 32'h1234_5678);
`ifdef ALU_OVERFLOW_EN
    check("async_ovq", {31'd0, overflow_q}, 32'd0);
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_cq", C_q, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    A = 32'hDEAD_0000; B = 32'h0000_BEEF; ALUOp = 3'b101;
    hold_c = model_c(A, B, ALUOp);
    #1;
    check("pre_rel_cq", C_q, 32'd0);
    @(posedge clk);
    #1;
    check("rel_cq", C_q, hold_c);

    // Random sweep over all opcodes
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      apply(ra, rb, 3'(i % 8));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
